// File: rtl/lc3b_types.sv
// rtl/lc3b_types.sv - LC-3b shared types: opcodes, control word, register index
package lc3b_types;

    typedef logic [2:0] lc3b_reg;

    typedef enum logic [3:0] {
        op_br   = 4'b0000,
        op_add  = 4'b0001,
        op_ldb  = 4'b0010,
        op_stb  = 4'b0011,
        op_jsr  = 4'b0100,
        op_and  = 4'b0101,
        op_ldr  = 4'b0110,
        op_str  = 4'b0111,
        op_rti  = 4'b1000,
        op_not  = 4'b1001,
        op_ldi  = 4'b1010,
        op_sti  = 4'b1011,
        op_jmp  = 4'b1100,
        op_shf  = 4'b1101,
        op_lea  = 4'b1110,
        op_trap = 4'b1111
    } lc3b_opcode;

    typedef struct packed {
        lc3b_opcode  opcode;
        logic        load_regfile;
        logic        load_cc;
        logic        load_pc;
        logic        mem_read;
        logic        mem_write;
        logic [1:0]  mem_byte_enable;
    } lc3b_control_word;

    // Bubble muxes in the datapath select this word: a BR that never branches and writes nothing.
    localparam lc3b_control_word lc3b_nop_ctrl = '{
        opcode:          op_br,
        load_regfile:    1'b0,
        load_cc:         1'b0,
        load_pc:         1'b0,
        mem_read:        1'b0,
        mem_write:       1'b0,
        mem_byte_enable: 2'b11
    };

endpackage

// File: rtl/lc3b_pipeline_ctrl_sat_counter.sv
// rtl/lc3b_pipeline_ctrl_sat_counter.sv - saturating up-counter with 0..3 increment
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [1:0]   inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;
    logic [W:0]   sum;

    // One guard bit catches any overflow, including a +3 that crosses the maximum.
    assign sum     = {1'b0, count_q} + (W+1)'(inc);
    assign count_d = sum[W] ? {W{1'b1}} : sum[W-1:0];
    assign count   = count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/lc3b_pipeline_ctrl.sv
// rtl/lc3b_pipeline_ctrl.sv - stall/flush sequencer for the five-stage LC-3b pipeline
module lc3b_pipeline_ctrl
    import lc3b_types::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             imem_resp,
    output logic             imem_read,
    input  logic             mem_stage_read,
    input  logic             mem_stage_write,
    input  logic             dmem_resp,
    output logic             dmem_read,
    output logic             dmem_write,
    input  logic             ex_mem_read,
    input  logic             ex_load_regfile,
    input  lc3b_reg          ex_dest,
    input  lc3b_reg          id_src1,
    input  lc3b_reg          id_src2,
    input  logic             id_use1,
    input  logic             id_use2,
    input  logic             mem_branch_taken,
    output logic             load_pc,
    output logic             load_if_id,
    output logic             load_id_ex,
    output logic             load_ex_mem,
    output logic             load_mem_wb,
    output logic             bubble_if_id,
    output logic             bubble_id_ex,
    output logic             bubble_ex_mem,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] bubble_count
);

    logic       i_done_q, i_done_d;
    logic       d_done_q, d_done_d;
    logic       i_ok, d_req, d_ok, advance, hz, fl;
    logic [1:0] stall_inc, bubble_inc;

    assign i_ok    = imem_resp | i_done_q;
    assign d_req   = mem_stage_read | mem_stage_write;
    assign d_ok    = ~d_req | dmem_resp | d_done_q;
    assign advance = i_ok & d_ok;
    assign fl      = mem_branch_taken & advance;
    assign hz      = ex_mem_read & ex_load_regfile &
                     ((id_use1 & (id_src1 == ex_dest)) | (id_use2 & (id_src2 == ex_dest)));

    always_comb begin
        load_pc       = 1'b0;
        load_if_id    = 1'b0;
        load_id_ex    = 1'b0;
        load_ex_mem   = 1'b0;
        load_mem_wb   = 1'b0;
        bubble_if_id  = 1'b0;
        bubble_id_ex  = 1'b0;
        bubble_ex_mem = 1'b0;
        imem_read     = 1'b0;
        dmem_read     = 1'b0;
        dmem_write    = 1'b0;
        stall_inc     = 2'd0;
        bubble_inc    = 2'd0;
        i_done_d      = 1'b0;
        d_done_d      = 1'b0;
        if (reset) begin
            // Push NOPs through the back half so no stale control word survives reset.
            load_id_ex    = 1'b1;
            load_ex_mem   = 1'b1;
            load_mem_wb   = 1'b1;
            bubble_id_ex  = 1'b1;
            bubble_ex_mem = 1'b1;
        end else begin
            imem_read  = ~i_done_q;
            dmem_read  = mem_stage_read & ~d_done_q;
            dmem_write = mem_stage_write & ~d_done_q;
            i_done_d   = advance ? 1'b0 : i_ok;
            d_done_d   = advance ? 1'b0 : (d_req & (dmem_resp | d_done_q));
            if (!advance) begin
                stall_inc = 2'd1;
            end else if (fl) begin
                load_pc       = 1'b1;
                load_if_id    = 1'b1;
                load_id_ex    = 1'b1;
                load_ex_mem   = 1'b1;
                load_mem_wb   = 1'b1;
                bubble_if_id  = 1'b1;
                bubble_id_ex  = 1'b1;
                bubble_ex_mem = 1'b1;
                bubble_inc    = 2'd3;
            end else if (hz) begin
                load_id_ex   = 1'b1;
                load_ex_mem  = 1'b1;
                load_mem_wb  = 1'b1;
                bubble_id_ex = 1'b1;
                bubble_inc   = 2'd1;
            end else begin
                load_pc     = 1'b1;
                load_if_id  = 1'b1;
                load_id_ex  = 1'b1;
                load_ex_mem = 1'b1;
                load_mem_wb = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            i_done_q <= 1'b0;
            d_done_q <= 1'b0;
        end else begin
            i_done_q <= i_done_d;
            d_done_q <= d_done_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_inc),
        .count (stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (bubble_inc),
        .count (bubble_count)
    );

endmodule

// File: tb/tb_lc3b_pipeline_ctrl.sv
// tb/tb_lc3b_pipeline_ctrl.sv - directed self-checking bench for lc3b_pipeline_ctrl
module tb_lc3b_pipeline_ctrl;

    logic clk = 1'b0;
    logic reset;
    logic imem_resp, mem_stage_read, mem_stage_write, dmem_resp;
    logic ex_mem_read, ex_load_regfile, id_use1, id_use2, mem_branch_taken;
    logic [2:0] ex_dest, id_src1, id_src2;

    logic imem_read, dmem_read, dmem_write;
    logic load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb;
    logic bubble_if_id, bubble_id_ex, bubble_ex_mem;
    logic [15:0] stall_cycles, bubble_count;

    logic s_imem_read, s_dmem_read, s_dmem_write;
    logic s_load_pc, s_load_if_id, s_load_id_ex, s_load_ex_mem, s_load_mem_wb;
    logic s_bubble_if_id, s_bubble_id_ex, s_bubble_ex_mem;
    logic [1:0] s_stall_cycles, s_bubble_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    lc3b_pipeline_ctrl #(.CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .imem_resp(imem_resp), .imem_read(imem_read),
        .mem_stage_read(mem_stage_read), .mem_stage_write(mem_stage_write),
        .dmem_resp(dmem_resp), .dmem_read(dmem_read), .dmem_write(dmem_write),
        .ex_mem_read(ex_mem_read), .ex_load_regfile(ex_load_regfile), .ex_dest(ex_dest),
        .id_src1(id_src1), .id_src2(id_src2), .id_use1(id_use1), .id_use2(id_use2),
        .mem_branch_taken(mem_branch_taken),
        .load_pc(load_pc), .load_if_id(load_if_id), .load_id_ex(load_id_ex),
        .load_ex_mem(load_ex_mem), .load_mem_wb(load_mem_wb),
        .bubble_if_id(bubble_if_id), .bubble_id_ex(bubble_id_ex), .bubble_ex_mem(bubble_ex_mem),
        .stall_cycles(stall_cycles), .bubble_count(bubble_count)
    );

    // Narrow-counter copy sharing all stimulus, used to reach saturation in a few cycles.
    lc3b_pipeline_ctrl #(.CNT_W(2)) dut_small (
        .clk(clk), .reset(reset),
        .imem_resp(imem_resp), .imem_read(s_imem_read),
        .mem_stage_read(mem_stage_read), .mem_stage_write(mem_stage_write),
        .dmem_resp(dmem_resp), .dmem_read(s_dmem_read), .dmem_write(s_dmem_write),
        .ex_mem_read(ex_mem_read), .ex_load_regfile(ex_load_regfile), .ex_dest(ex_dest),
        .id_src1(id_src1), .id_src2(id_src2), .id_use1(id_use1), .id_use2(id_use2),
        .mem_branch_taken(mem_branch_taken),
        .load_pc(s_load_pc), .load_if_id(s_load_if_id), .load_id_ex(s_load_id_ex),
        .load_ex_mem(s_load_ex_mem), .load_mem_wb(s_load_mem_wb),
        .bubble_if_id(s_bubble_if_id), .bubble_id_ex(s_bubble_id_ex), .bubble_ex_mem(s_bubble_ex_mem),
        .stall_cycles(s_stall_cycles), .bubble_count(s_bubble_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        imem_resp = 1'b1; mem_stage_read = 1'b0; mem_stage_write = 1'b0; dmem_resp = 1'b0;
        ex_mem_read = 1'b0; ex_load_regfile = 1'b0; ex_dest = 3'd0;
        id_src1 = 3'd1; id_src2 = 3'd2; id_use1 = 1'b0; id_use2 = 1'b0;
        mem_branch_taken = 1'b0;
    endtask

    // Packs {load_pc,if_id,id_ex,ex_mem,mem_wb,bub_if_id,bub_id_ex,bub_ex_mem}.
    function automatic logic [7:0] ctl();
        return {load_pc, load_if_id, load_id_ex, load_ex_mem, load_mem_wb,
                bubble_if_id, bubble_id_ex, bubble_ex_mem};
    endfunction

    initial begin
        idle();
        reset = 1'b1;
        mem_stage_read = 1'b1;
        mem_stage_write = 1'b1;
        #1;
        chk("reset_ctl", ctl(), 8'b0011_1011);
        chk("reset_imem_read", imem_read, 1'b0);
        chk("reset_dmem_rw", {dmem_read, dmem_write}, 2'b00);
        tick();
        tick();
        chk("reset_counters", {stall_cycles, bubble_count}, 32'h0);
        reset = 1'b0;
        idle();

        // Free-running: every cycle advances.
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("run_ctl", ctl(), 8'b1111_1000);
            chk("run_imem_read", imem_read, 1'b1);
            tick();
        end
        chk("run_stall_cnt", stall_cycles, 16'd0);

        // D-stall: cycle0 both busy, cycle1 imem done, cycles2-3 waiting on dmem, cycle4 dmem done.
        mem_stage_read = 1'b1; imem_resp = 1'b0; #1;
        chk("ds0_ctl", ctl(), 8'h00);
        tick();
        imem_resp = 1'b1; #1;
        chk("ds1_ctl", ctl(), 8'h00);
        chk("ds1_reqs", {imem_read, dmem_read}, 2'b11);
        tick();
        imem_resp = 1'b0;
        for (int i = 2; i < 4; i++) begin
            #1;
            chk("ds_wait_reqs", {imem_read, dmem_read}, 2'b01);
            chk("ds_wait_ctl", ctl(), 8'h00);
            tick();
        end
        dmem_resp = 1'b1; #1;
        chk("ds4_ctl", ctl(), 8'b1111_1000);
        chk("ds4_imem_read", imem_read, 1'b0);
        tick();
        idle(); #1;
        chk("ds_after_imem_read", imem_read, 1'b1);
        chk("ds_stall_cnt", stall_cycles, 16'd4);
        chk("ds_small_stall_sat", s_stall_cycles, 2'd3);

        // Load-use through src1.
        ex_mem_read = 1'b1; ex_load_regfile = 1'b1; ex_dest = 3'd3; id_src1 = 3'd3; id_use1 = 1'b1; #1;
        chk("hz1_ctl", ctl(), 8'b0011_1010);
        tick();
        chk("hz1_bubble_cnt", bubble_count, 16'd1);
        idle(); #1;
        chk("hz1_next_ctl", ctl(), 8'b1111_1000);
        tick();

        // Load-use through src2 only.
        ex_mem_read = 1'b1; ex_load_regfile = 1'b1; ex_dest = 3'd5;
        id_src1 = 3'd1; id_use1 = 1'b1; id_src2 = 3'd5; id_use2 = 1'b1; #1;
        chk("hz2_ctl", ctl(), 8'b0011_1010);
        tick();
        chk("hz2_bubble_cnt", bubble_count, 16'd2);

        // Matching src that is not read is not a hazard.
        ex_dest = 3'd6; id_src1 = 3'd6; id_use1 = 1'b0; id_src2 = 3'd2; id_use2 = 1'b1; #1;
        chk("nohz_ctl", ctl(), 8'b1111_1000);
        tick();

        // Hazard plus taken branch: flush wins.
        ex_dest = 3'd3; id_src1 = 3'd3; id_use1 = 1'b1; mem_branch_taken = 1'b1; #1;
        chk("flhz_ctl", ctl(), 8'b1111_1111);
        tick();
        chk("flhz_bubble_cnt", bubble_count, 16'd5);
        chk("flhz_small_clamp", s_bubble_count, 2'd3);

        // Taken branch held back by a pending store.
        idle();
        mem_branch_taken = 1'b1; mem_stage_write = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("brw_ctl", ctl(), 8'h00);
            chk("brw_dmem_write", dmem_write, 1'b1);
            tick();
        end
        dmem_resp = 1'b1; #1;
        chk("brw_flush_ctl", ctl(), 8'b1111_1111);
        tick();
        chk("brw_counters", {stall_cycles, bubble_count}, {16'd6, 16'd8});
        chk("brw_small_counters", {s_stall_cycles, s_bubble_count}, 4'hF);

        // Simultaneous responses: advance, no sticky bit left behind.
        idle();
        mem_stage_read = 1'b1; dmem_resp = 1'b1; #1;
        chk("simul_ctl", ctl(), 8'b1111_1000);
        tick();
        dmem_resp = 1'b0; imem_resp = 1'b0; #1;
        chk("simul_after_reqs", {imem_read, dmem_read}, 2'b11);
        tick();

        // Reset in the middle of a D-stall.
        imem_resp = 1'b1; #1;
        tick();
        imem_resp = 1'b0; #1;
        chk("rds_pre_imem_read", imem_read, 1'b0);
        reset = 1'b1; #1;
        chk("rds_reset_dmem_read", dmem_read, 1'b0);
        tick();
        reset = 1'b0; #1;
        chk("rds_counters", {stall_cycles, bubble_count}, 32'h0);
        chk("rds_reqs_reissued", {imem_read, dmem_read}, 2'b11);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
